xup_nor_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one external SIZE-bit vector NOR unit between NREQ requesters.
- Per granted transaction: drives the winner's operands onto the shared unit, waits a fixed settle interval to cover gate propagation delay, captures the result and returns it to the winner over a valid/ready handshake.
- Sits between lab-level requester logic and a single instantiated vector NOR gate.

---
 rtl/xup_nor_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_xup_nor_share_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xup_nor_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one external SIZE-bit vector NOR unit among NREQ requesters.
// Optional macro XUP_NOR_CHECK_EN adds a sticky chk_err output comparing gate_y to ~(gate_a | gate_b) at capture.
module xup_nor_share_arbiter #(
    parameter int SIZE   = 8,
    parameter int NREQ   = 4,
    parameter int SETTLE = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*SIZE-1:0]     a_in,
    input  logic [NREQ*SIZE-1:0]     b_in,
    output logic [NREQ-1:0]          gnt,
    output logic [SIZE-1:0]          gate_a,
    output logic [SIZE-1:0]          gate_b,
    input  logic [SIZE-1:0]          gate_y,
    output logic [SIZE-1:0]          res,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     busy
`ifdef XUP_NOR_CHECK_EN
    ,
    output logic                     chk_err
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int IW1 = IDW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [IDW-1:0]  win_reg;
    logic [IDW-1:0]  rr_reg;
    logic [3:0]      cnt_reg;
    logic [IDW-1:0]  pick_idx;
    logic            pick_valid;
    logic [IDW-1:0]  rr_next;

    logic [SIZE-1:0] a_arr [NREQ];
    logic [SIZE-1:0] b_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi] = a_in[gi*SIZE +: SIZE];
            assign b_arr[gi] = b_in[gi*SIZE +: SIZE];
        end
    endgenerate

    // First requester found scanning upward from rr_reg, wrapping at NREQ.
    always_comb begin : pick_blk
        logic [IW1-1:0] sum_v;
        pick_valid = 1'b0;
        pick_idx   = '0;
        sum_v      = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum_v = {1'b0, rr_reg} + IW1'(i);
            if (sum_v >= IW1'(NREQ)) begin
                sum_v = sum_v - IW1'(NREQ);
            end
            if (!pick_valid && req[sum_v[IDW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = sum_v[IDW-1:0];
            end
        end
    end

    assign rr_next = (win_reg == IDW'(NREQ - 1)) ? '0 : win_reg + IDW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (pick_valid) state_next = S_ISSUE;
            S_ISSUE:  state_next = S_SETTLE;
            S_SETTLE: if (cnt_reg == 4'd0) state_next = S_DONE;
            S_DONE:   if (res_valid && res_ready) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg != S_IDLE);
        gnt  = '0;
        if (state_reg != S_IDLE) begin
            gnt[win_reg] = 1'b1;
        end
    end

    // Datapath: operands frozen at ISSUE, result captured when the settle count expires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_reg   <= '0;
            rr_reg    <= '0;
            cnt_reg   <= '0;
            gate_a    <= '0;
            gate_b    <= '0;
            res       <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
`ifdef XUP_NOR_CHECK_EN
            chk_err   <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pick_valid) begin
                        win_reg <= pick_idx;
                    end
                end
                S_ISSUE: begin
                    gate_a  <= a_arr[win_reg];
                    gate_b  <= b_arr[win_reg];
                    cnt_reg <= 4'(SETTLE - 1);
                end
                S_SETTLE: begin
                    if (cnt_reg == 4'd0) begin
                        res       <= gate_y;
                        res_id    <= win_reg;
                        res_valid <= 1'b1;
`ifdef XUP_NOR_CHECK_EN
                        if (gate_y != ~(gate_a | gate_b)) begin
                            chk_err <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                S_DONE: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        rr_reg    <= rr_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_xup_nor_share_arbiter.sv
// Directed self-checking bench for xup_nor_share_arbiter (SIZE=8, NREQ=4, SETTLE=3) with a behavioural NOR unit.
module tb_xup_nor_share_arbiter;

    localparam int SIZE   = 8;
    localparam int NREQ   = 4;
    localparam int SETTLE = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NREQ-1:0]     req;
    logic [NREQ*SIZE-1:0] a_in;
    logic [NREQ*SIZE-1:0] b_in;
    logic [NREQ-1:0]     gnt;
    logic [SIZE-1:0]     gate_a;
    logic [SIZE-1:0]     gate_b;
    logic [SIZE-1:0]     gate_y;
    logic [SIZE-1:0]     res;
    logic [1:0]          res_id;
    logic                res_valid;
    logic                res_ready;
    logic                busy;
`ifdef XUP_NOR_CHECK_EN
    logic                chk_err;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural shared NOR unit: optional stuck-low bits and a 2-cycle output delay.
    logic [SIZE-1:0] stuck_mask = '0;
    int              gate_dly   = 0;
    logic [SIZE-1:0] y_now;
    logic [SIZE-1:0] y_d1 = '0;
    logic [SIZE-1:0] y_d2 = '0;

    assign y_now  = ~(gate_a | gate_b) & ~stuck_mask;
    assign gate_y = (gate_dly == 2) ? y_d2 : y_now;

    always @(posedge clk) begin
        y_d1 <= y_now;
        y_d2 <= y_d1;
    end

    always #5 clk = ~clk;

    xup_nor_share_arbiter #(
        .SIZE   (SIZE),
        .NREQ   (NREQ),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .gate_a    (gate_a),
        .gate_b    (gate_b),
        .gate_y    (gate_y),
        .res       (res),
        .res_id    (res_id),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
`ifdef XUP_NOR_CHECK_EN
        ,
        .chk_err   (chk_err)
`endif
    );

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout res_valid=%b required 1", tag, res_valid);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle_timeout busy=%b required 0", tag, busy);
        end
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        a_in[i*SIZE +: SIZE] = a;
        b_in[i*SIZE +: SIZE] = b;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, busy, res_valid, res_id} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl gnt=%b busy=%b res_valid=%b res_id=%0d required all 0",
                     gnt, busy, res_valid, res_id);
        end
        checks++;
        if ({gate_a, gate_b, res} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data gate_a=%h gate_b=%h res=%h required 0", gate_a, gate_b, res);
        end
`ifdef XUP_NOR_CHECK_EN
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_chk_err chk_err=%b required 0", chk_err);
        end
`endif
        reset_n = 1'b1;
        @(negedge clk);
        $display("reset: outputs cleared");
    endtask

    task automatic test_single();
        set_ops(0, 8'h0F, 8'h30);
        req = 4'b0001;
        for (int k = 0; k <= SETTLE; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (gnt !== 4'b0001 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_grant gnt=%b busy=%b required 0001/1", gnt, busy);
                end
            end
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_early_valid cycle=%0d res_valid=%b required 0", k, res_valid);
            end
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res !== 8'hC0 || res_id !== 2'd0) begin
            errors++;
            $display("FAIL single_result valid=%b res=%h id=%0d required 1/c0/0", res_valid, res, res_id);
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_return busy=%b valid=%b gnt=%b required 0/0/0000", busy, res_valid, gnt);
        end
        $display("single: res=%h id=%0d", 8'hC0, 0);
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id [5];
        logic [7:0] exp_y  [4];
        exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
        exp_y[0] = 8'hEE; exp_y[1] = 8'hDD; exp_y[2] = 8'hB3; exp_y[3] = 8'h78;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        set_ops(0, 8'h01, 8'h10);
        set_ops(1, 8'h22, 8'h02);
        set_ops(2, 8'h44, 8'h08);
        set_ops(3, 8'h80, 8'h07);
        res_ready = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            wait_valid("rr");
            checks++;
            if (res_id !== exp_id[j] || gnt !== (4'b0001 << exp_id[j]) || res !== exp_y[exp_id[j]]) begin
                errors++;
                $display("FAIL rr_txn%0d id=%0d gnt=%b res=%h required id=%0d res=%h",
                         j, res_id, gnt, res, exp_id[j], exp_y[exp_id[j]]);
            end
            $display("rr: txn %0d id=%0d res=%h", j, res_id, res);
            if (j == 4) req = '0;
            @(negedge clk);
        end
        wait_idle("rr");
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        req = 4'b0101;
        @(negedge clk);
        wait_valid("bp");
        checks++;
        if (res_id !== 2'd2 || gnt !== 4'b0100 || res !== 8'hB3) begin
            errors++;
            $display("FAIL bp_first id=%0d gnt=%b res=%h required 2/0100/b3", res_id, gnt, res);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_id !== 2'd2 || res !== 8'hB3 || gnt !== 4'b0100) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d valid=%b id=%0d res=%h gnt=%b required 1/2/b3/0100",
                         k, res_valid, res_id, res, gnt);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release valid=%b busy=%b required 0/0", res_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL bp_next_grant gnt=%b required 0001", gnt);
        end
        wait_valid("bp2");
        checks++;
        if (res_id !== 2'd0 || res !== 8'hEE) begin
            errors++;
            $display("FAIL bp_second id=%0d res=%h required 0/ee", res_id, res);
        end
        req = '0;
        @(negedge clk);
        wait_idle("bp");
        $display("backpressure: held 10 cycles, next id=0");
    endtask

    task automatic test_latched_operands();
        gate_dly = 2;
        set_ops(0, 8'h0F, 8'h30);
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL latch_grant gnt=%b required 0001", gnt);
        end
        @(negedge clk);
        checks++;
        if (gate_a !== 8'h0F || gate_b !== 8'h30) begin
            errors++;
            $display("FAIL latch_gate gate_a=%h gate_b=%h required 0f/30", gate_a, gate_b);
        end
        set_ops(0, 8'hFF, 8'h30);
        wait_valid("latch");
        checks++;
        if (res !== 8'hC0 || gate_a !== 8'h0F) begin
            errors++;
            $display("FAIL latch_result res=%h gate_a=%h required c0/0f", res, gate_a);
        end
`ifdef XUP_NOR_CHECK_EN
        checks++;
        if (chk_err !== 1'b0) begin
            errors++;
            $display("FAIL latch_chk_err chk_err=%b required 0", chk_err);
        end
`endif
        req = '0;
        @(negedge clk);
        wait_idle("latch");
        checks++;
        if (gate_a !== 8'h0F || gate_b !== 8'h30) begin
            errors++;
            $display("FAIL latch_idle_hold gate_a=%h gate_b=%h required 0f/30", gate_a, gate_b);
        end
        $display("latched: res=%h with a_in changed after issue", 8'hC0);
    endtask

    task automatic test_reset_mid();
        set_ops(0, 8'h0F, 8'h30);
        req = 4'b1001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL rmid_grant gnt=%b required 1000", gnt);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt, busy, res_valid, res_id} !== 8'h00 || {gate_a, gate_b, res} !== 24'h0) begin
            errors++;
            $display("FAIL rmid_async gnt=%b busy=%b valid=%b id=%0d gate_a=%h gate_b=%h res=%h required 0",
                     gnt, busy, res_valid, res_id, gate_a, gate_b, res);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rmid_rearb gnt=%b busy=%b required 0001/1", gnt, busy);
        end
        wait_valid("rmid");
        checks++;
        if (res_id !== 2'd0 || res !== 8'hC0) begin
            errors++;
            $display("FAIL rmid_result id=%0d res=%h required 0/c0", res_id, res);
        end
        req = '0;
        @(negedge clk);
        wait_idle("rmid");
        $display("reset_mid: re-arbitrated to id=0");
    endtask

`ifdef XUP_NOR_CHECK_EN
    task automatic test_chk_err();
        gate_dly   = 0;
        stuck_mask = 8'h01;
        set_ops(0, 8'h00, 8'h00);
        req = 4'b0001;
        @(negedge clk);
        wait_valid("chk");
        checks++;
        if (res !== 8'hFE || chk_err !== 1'b1) begin
            errors++;
            $display("FAIL chk_set res=%h chk_err=%b required fe/1", res, chk_err);
        end
        req = '0;
        @(negedge clk);
        wait_idle("chk");
        stuck_mask = '0;
        req = 4'b0001;
        @(negedge clk);
        wait_valid("chk2");
        checks++;
        if (res !== 8'hFF || chk_err !== 1'b1) begin
            errors++;
            $display("FAIL chk_sticky res=%h chk_err=%b required ff/1", res, chk_err);
        end
        req = '0;
        @(negedge clk);
        wait_idle("chk");
        $display("chk_err: sticky after stuck-bit capture");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_latched_operands();
        test_reset_mid();
`ifdef XUP_NOR_CHECK_EN
        test_chk_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
